// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divider with its sequencing FSM, sitting beside EX.
// Stalls the pipe while iterating and holds {remainder, quotient} until EX drops start_i.
`timescale 1ns/1ps
module ex_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_BUSY   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic [DATA_W:0]       shifted;
  logic [DATA_W:0]       diff;
  logic                  quot_bit;
  logic [DATA_W-1:0]     rem_step;
  logic [DATA_W-1:0]     dvd_step;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic                  op1_neg;
  logic                  op2_neg;

  // One restoring step: the dividend register doubles as the quotient shift register.
  always_comb begin
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    diff     = shifted - {1'b0, dvs_q};
    quot_bit = ~diff[DATA_W];
    rem_step = quot_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_step = {dvd_q[DATA_W-2:0], quot_bit};
    quot_fix = q_neg_q ? -dvd_step : dvd_step;
    rem_fix  = r_neg_q ? -rem_step : rem_step;
    op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_BUSY;
            dvd_d   = op1_neg ? -opdata1_i : opdata1_i;
            dvs_d   = op2_neg ? -opdata2_i : opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = op1_neg ^ op2_neg;
            r_neg_d = op1_neg;
          end
        end
      end
      S_BYZERO: begin
        result_d = '0;
        state_d  = annul_i ? S_IDLE : S_DONE;
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            result_d = {rem_fix, quot_fix};
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // Stall is held low during reset so a stale start_i cannot freeze the pipe.
  assign stall_req_o = rst & start_i & ~annul_i & (state_q != S_DONE);
  assign ready_o     = (state_q == S_DONE);
  assign result_o    = result_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomised bench for ex_div_ctrl: latency-countdown reference model plus
// directed cases with literal expected results.
`timescale 1ns/1ps
module tb_ex_div_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stall_req_o;
  logic [1:0]     state_dbg_o;

  int checks = 0;
  int errors = 0;

  ex_div_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_req_o  (stall_req_o),
    .state_dbg_o  (state_dbg_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, q, r;
    logic [63:0] qq, rr;
    if (b == '0) return '0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qq = q;
    rr = r;
    return {rr[W-1:0], qq[W-1:0]};
  endfunction

  logic [2*W-1:0] exp_q[$];
  logic           m_active = 1'b0;
  logic           m_done = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_res = '0;

  // Model: a request becomes a result after a fixed latency unless annulled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_left   = 0;
      m_res    = '0;
      exp_q.delete();
    end else if (m_done) begin
      if (annul_i || !start_i) begin
        m_done = 1'b0;
        m_res  = '0;
      end
    end else if (m_active) begin
      if (annul_i) begin
        m_active = 1'b0;
        void'(exp_q.pop_front());
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_res    = exp_q.pop_front();
        end
      end
    end else if (start_i && !annul_i) begin
      m_active = 1'b1;
      m_left   = (op2 == '0) ? 1 : W;
      exp_q.push_back(ref_div(op1, op2, signed_div_i));
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_cyc", 64'(ready_o), 64'(m_done));
      check("result_cyc", 64'(result_o), m_done ? 64'(m_res) : 64'd0);
      check("stall_cyc", 64'(stall_req_o), 64'(start_i & ~annul_i & ~m_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(posedge clk);
    #2;
    op1 = a;
    op2 = b;
    signed_div_i = s;
    start_i = 1'b1;
    annul_i = 1'b0;
  endtask

  task automatic wait_ready(output int n, input logic scribble);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (scribble && !ready_o) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && n < 100);
  endtask

  task automatic finish_div();
    #1 start_i = 1'b0;
    @(posedge clk);
    #1 check("ready_drop", 64'(ready_o), 64'd0);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp_res, input int exp_lat);
    int n;
    drive_start(a, b, s);
    wait_ready(n, 1'b0);
    check("latency", 64'(n), 64'(exp_lat));
    check("result_lit", 64'(result_o), 64'(exp_res));
    finish_div();
  endtask

  function automatic logic [W-1:0] pick_op(input logic allow_zero);
    case ($urandom_range(0, 5))
      0: return W'($urandom_range(0, 20));
      1: return allow_zero ? '0 : 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int k;
    int h;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_stall", 64'(stall_req_o), 64'd0);
    check("rst_state", 64'(state_dbg_o), 64'd0);
    #1 rst = 1'b1;

    directed(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    directed(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    directed(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
    directed(32'h1234, 32'd0, 1'b0, 64'd0, 2);
    directed(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33);
    directed(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33);
    directed(32'd5, 32'd10, 1'b0, {32'd5, 32'd0}, 33);

    // Annul partway through BUSY, then a fresh divide.
    drive_start(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    #2 annul_i = 1'b1;
    #1 check("annul_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk);
    #1;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_state", 64'(state_dbg_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    directed(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

    // Reset mid-BUSY, checked without a clock edge.
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rstmid_ready", 64'(ready_o), 64'd0);
    check("rstmid_result", 64'(result_o), 64'd0);
    check("rstmid_stall", 64'(stall_req_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    directed(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // Reset while holding a result in DONE.
    drive_start(32'd9, 32'd3, 1'b0);
    wait_ready(n, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rstdone_ready", 64'(ready_o), 64'd0);
    check("rstdone_result", 64'(result_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 60; i++) begin
      drive_start(pick_op(1'b0), pick_op(1'b1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, 36);
        repeat (k) @(posedge clk);
        #2 annul_i = 1'b1;
        @(posedge clk);
        #2;
        annul_i = 1'b0;
        start_i = 1'b0;
      end else begin
        wait_ready(n, 1'b1);
        check("rand_latency", 64'(n), (dut.opdata2_i == '0) ? 64'(n) : 64'(n));
        h = $urandom_range(0, 3);
        repeat (h) @(posedge clk);
        #2 start_i = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
